register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Storage stage of the register file: eight WIDTH-bit registers.
- Written through an 8-bit one-hot write-enable vector `to_reg`, produced by the upstream write-decode stage (3-to-8 decoder gated by `we`).
- Two registered read ports, selected by 3-bit addresses, feed the downstream datapath.
- Malformed enable vectors (more than one bit set) are detected, the write is suppressed, and a sticky error flag and saturating event counter record the fault.

Parameters:
- WIDTH, 32, data width of each register and of wData/rData0/rData1.
- CNT_W, 8, width of the illegal-write event counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- to_reg  input  8  one-hot write enables; bit i selects register i; all-zero means no write.
- wData  input  WIDTH  write data, sampled at the rising clk edge.
- rAddr0  input  3  read port 0 register index.
- rAddr1  input  3  read port 1 register index.
- rData0  output  WIDTH  read port 0 data, registered.
- rData1  output  WIDTH  read port 1 data, registered.
- err_multi  output  1  sticky flag: a multi-hot to_reg was seen.
- illegal_cnt  output  CNT_W  count of multi-hot write attempts, saturating.

Behaviour:
- Clock and reset:
  - One clock, clk. All state updates occur on the rising edge.
  - reset_n is sampled only at the rising edge (synchronous, active-low).
  - When reset_n=0 at an edge: all eight registers=0, rData0=0, rData1=0, err_multi=0, illegal_cnt=0.
  - Reset has priority over any write, read or error update in the same cycle.
  - Reset asserted mid-sequence discards the in-flight write and read.
- Enable classification, evaluated each cycle on to_reg:
  - ZERO: to_reg=8'h00. No write.
  - ONEHOT: exactly one bit set. Register i <= wData at the edge.
  - MULTI: two or more bits set. No register written. err_multi <= 1. illegal_cnt <= illegal_cnt+1, saturating at 2^CNT_W-1 (holds 255 at default).
- Error recovery:
  - err_multi stays set until reset. There is no other clear path.
  - ZERO and ONEHOT cycles leave err_multi and illegal_cnt unchanged.
- Read ports:
  - rDataN <= reg[rAddrN] at every rising edge.
  - Latency: one cycle from address to rDataN.
  - Both ports are independent. Equal addresses are legal and return identical data.
- Read/write collision, same edge, ONEHOT write to register k and rAddrN=k:
  - Base behaviour (no bypass): rDataN captures the old contents of k.
  - The new value is visible one cycle later.
- MULTI collisions: a read of any register returns the old contents, since no write occurs.
- No handshake; the block accepts a write and two reads every cycle.
- Register contents persist indefinitely with to_reg=0.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined:
  - On a ONEHOT write to k with rAddrN=k in the same cycle, rDataN captures wData, i.e. write-through forwarding.
  - Each read port forwards independently.
  - MULTI cycles never forward.
- Undefined:
  - No forwarding logic is built.
  - Collision reads return the pre-write value, as specified under Behaviour.

Test Plan:
- Reset check: drive reset_n=0 for 2 edges with to_reg=8'h01, wData=32'hFFFF_FFFF, then release and read all 8 addresses. Required: every rData=0, err_multi=0, illegal_cnt=0, and register 0 not written.
- Write/readback: write 32'h1000_0000+i to register i via to_reg=1<<i, for i=0..7, then read rAddr0=i, rAddr1=7-i. Required: rData0=32'h1000_0000+i and rData1=32'h1000_0000+(7-i), each one cycle after the address is applied.
- Multi-hot suppression: preload reg2=32'hAAAA_AAAA and reg5=32'h5555_5555, then apply to_reg=8'h24 with wData=32'h0. Required: both registers unchanged, err_multi=1, illegal_cnt=1. A following to_reg=8'h04 write succeeds and err_multi stays 1.
- Counter saturation: 300 consecutive cycles with to_reg=8'hFF. Required: illegal_cnt=255 and holds there; all registers unchanged.
- Collision: reg3=32'h0000_0011, then write to_reg=8'h08 with wData=32'h0000_0022 while rAddr0=3. Required:
  - Without REGBANK_BYPASS_EN: rData0=32'h0000_0011 next cycle, then 32'h0000_0022.
  - With REGBANK_BYPASS_EN: rData0=32'h0000_0022 immediately.
- Reset mid-operation: assert reset_n=0 on the same edge as to_reg=8'h80 with wData=32'hDEAD_BEEF and err_multi=1. Required: reg7=0, err_multi=0, rData0=rData1=0.

Source files
------------

// File: rtl/register_bank.sv
// register_bank: eight-entry register file storage stage.
// Define REGBANK_BYPASS_EN for write-through read forwarding.
module register_bank #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       to_reg,
  input  logic [WIDTH-1:0] wData,
  input  logic [2:0]       rAddr0,
  input  logic [2:0]       rAddr1,
  output logic [WIDTH-1:0] rData0,
  output logic [WIDTH-1:0] rData1,
  output logic             err_multi,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [WIDTH-1:0] r_regs [8];
  logic [WIDTH-1:0] r_rd0;
  logic [WIDTH-1:0] r_rd1;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_multi;
  logic             w_onehot;
  logic [WIDTH-1:0] w_rd0;
  logic [WIDTH-1:0] w_rd1;

  // x & (x-1) clears the lowest set bit; nonzero means 2+ bits
  assign w_multi  = |(to_reg & (to_reg - 8'd1));
  assign w_onehot = (|to_reg) & ~w_multi;

  // Read-port source select, with optional forwarding of wData
  always_comb begin
    w_rd0 = r_regs[rAddr0];
    w_rd1 = r_regs[rAddr1];
`ifdef REGBANK_BYPASS_EN
    if (w_onehot && to_reg[rAddr0]) w_rd0 = wData;
    if (w_onehot && to_reg[rAddr1]) w_rd1 = wData;
`else
`endif
  end

  // Register array: clear on reset, single-register write on one-hot
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (w_onehot) begin
      for (int i = 0; i < 8; i++) begin
        if (to_reg[i]) r_regs[i] <= wData;
      end
    end
  end

  // Registered read ports
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else begin
      r_rd0 <= w_rd0;
      r_rd1 <= w_rd1;
    end
  end

  // Sticky multi-hot flag and saturating event counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_multi) begin
      r_err <= 1'b1;
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign rData0      = r_rd0;
  assign rData1      = r_rd1;
  assign err_multi   = r_err;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: scoreboard bench for register_bank.
// Expected results are queued at drive time, compared after the edge.
module tb_register_bank;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        err;
    logic [7:0]  cnt;
  } res_t;

  logic        clk;
  logic        reset_n;
  logic [7:0]  to_reg;
  logic [31:0] wData;
  logic [2:0]  rAddr0;
  logic [2:0]  rAddr1;
  logic [31:0] rData0;
  logic [31:0] rData1;
  logic        err_multi;
  logic [7:0]  illegal_cnt;

  res_t        exp_q [$];
  res_t        obs_q [$];
  logic [31:0] m_regs [8];
  logic        m_err;
  logic [7:0]  m_cnt;
  int          checks;
  int          errors;

  register_bank #(
    .WIDTH (32),
    .CNT_W (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .to_reg      (to_reg),
    .wData       (wData),
    .rAddr0      (rAddr0),
    .rAddr1      (rAddr1),
    .rData0      (rData0),
    .rData1      (rData1),
    .err_multi   (err_multi),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(
    input logic [7:0]  tr,
    input logic [31:0] wd,
    input logic [2:0]  a0,
    input logic [2:0]  a1,
    input logic        rn
  );
    res_t e;
    res_t o;
    int   n;
    to_reg  = tr;
    wData   = wd;
    rAddr0  = a0;
    rAddr1  = a1;
    reset_n = rn;
    n = $countones(tr);
    if (!rn) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_err = 1'b0;
      m_cnt = '0;
      e = '0;
    end else begin
      e.d0 = m_regs[a0];
      e.d1 = m_regs[a1];
`ifdef REGBANK_BYPASS_EN
      if (n == 1 && tr[a0]) e.d0 = wd;
      if (n == 1 && tr[a1]) e.d1 = wd;
`endif
      if (n == 1) begin
        for (int i = 0; i < 8; i++)
          if (tr[i]) m_regs[i] = wd;
      end
      if (n > 1) begin
        m_err = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      e.err = m_err;
      e.cnt = m_cnt;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = '{rData0, rData1, err_multi, illegal_cnt};
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    res_t e;
    res_t o;
    drive(8'h01, 32'hFFFF_FFFF, 3'd0, 3'd0, 1'b0);
    drive(8'h01, 32'hFFFF_FFFF, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      drive(8'h00, 32'h0, 3'(i), 3'(7 - i), 1'b1);
    drive(8'h00, 32'h0, 3'd0, 3'd0, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset: got %h/%h/%b/%0d want %h/%h/%b/%0d",
          o.d0, o.d1, o.err, o.cnt, e.d0, e.d1, e.err, e.cnt);
      end
    end
    checks++;
    if (rData0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_reg0: got %h want 0", rData0);
    end
  endtask

  task automatic test_write_read;
    res_t e;
    res_t o;
    for (int i = 0; i < 8; i++)
      drive(8'(1 << i), 32'h1000_0000 + i, 3'd0, 3'd7, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(8'h00, 32'h0, 3'(i), 3'(7 - i), 1'b1);
      checks++;
      if (rData0 !== 32'h1000_0000 + i ||
          rData1 !== 32'h1000_0000 + (7 - i)) begin
        errors++;
        $display("FAIL readback %0d: got %h %h", i, rData0, rData1);
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wr_rd: got %h/%h/%b/%0d want %h/%h/%b/%0d",
          o.d0, o.d1, o.err, o.cnt, e.d0, e.d1, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_multi_hot;
    res_t e;
    res_t o;
    drive(8'h04, 32'hAAAA_AAAA, 3'd0, 3'd0, 1'b1);
    drive(8'h20, 32'h5555_5555, 3'd0, 3'd0, 1'b1);
    drive(8'h24, 32'h0, 3'd2, 3'd5, 1'b1);
    checks++;
    if (err_multi !== 1'b1 || illegal_cnt !== 8'd1) begin
      errors++;
      $display("FAIL multi_flag: got %b %0d want 1 1",
        err_multi, illegal_cnt);
    end
    drive(8'h00, 32'h0, 3'd2, 3'd5, 1'b1);
    checks++;
    if (rData0 !== 32'hAAAA_AAAA || rData1 !== 32'h5555_5555) begin
      errors++;
      $display("FAIL multi_keep: got %h %h", rData0, rData1);
    end
    drive(8'h04, 32'h1234_5678, 3'd2, 3'd5, 1'b1);
    drive(8'h00, 32'h0, 3'd2, 3'd5, 1'b1);
    checks++;
    if (rData0 !== 32'h1234_5678 || err_multi !== 1'b1) begin
      errors++;
      $display("FAIL multi_recover: got %h %b want 12345678 1",
        rData0, err_multi);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL multi: got %h/%h/%b/%0d want %h/%h/%b/%0d",
          o.d0, o.d1, o.err, o.cnt, e.d0, e.d1, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_saturation;
    res_t e;
    res_t o;
    for (int i = 0; i < 300; i++)
      drive(8'hFF, $urandom, 3'(i), 3'(i + 3), 1'b1);
    checks++;
    if (illegal_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturate: got %0d want 255", illegal_cnt);
    end
    for (int i = 0; i < 8; i++)
      drive(8'h00, 32'h0, 3'(i), 3'(7 - i), 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sat: got %h/%h/%b/%0d want %h/%h/%b/%0d",
          o.d0, o.d1, o.err, o.cnt, e.d0, e.d1, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_collision;
    res_t        e;
    res_t        o;
    logic [31:0] want;
`ifdef REGBANK_BYPASS_EN
    want = 32'h0000_0022;
`else
    want = 32'h0000_0011;
`endif
    drive(8'h08, 32'h0000_0011, 3'd0, 3'd1, 1'b1);
    drive(8'h08, 32'h0000_0022, 3'd3, 3'd0, 1'b1);
    checks++;
    if (rData0 !== want) begin
      errors++;
      $display("FAIL collide: got %h want %h", rData0, want);
    end
    drive(8'h00, 32'h0, 3'd3, 3'd3, 1'b1);
    checks++;
    if (rData0 !== 32'h22) begin
      errors++;
      $display("FAIL collide_next: got %h want 22", rData0);
    end
    drive(8'hC0, 32'hFFFF_0000, 3'd6, 3'd7, 1'b1);
    drive(8'h10, 32'h0000_0044, 3'd4, 3'd4, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL coll: got %h/%h/%b/%0d want %h/%h/%b/%0d",
          o.d0, o.d1, o.err, o.cnt, e.d0, e.d1, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid;
    res_t e;
    res_t o;
    drive(8'h80, 32'h0000_0077, 3'd0, 3'd1, 1'b1);
    drive(8'h03, 32'h0, 3'd7, 3'd7, 1'b1);
    drive(8'h80, 32'hDEAD_BEEF, 3'd7, 3'd7, 1'b0);
    checks++;
    if (err_multi !== 1'b0 || rData0 !== 32'h0 ||
        rData1 !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got %b %h %h", err_multi, rData0, rData1);
    end
    drive(8'h00, 32'h0, 3'd7, 3'd0, 1'b1);
    checks++;
    if (rData0 !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_reg7: got %h want 0", rData0);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rmid: got %h/%h/%b/%0d want %h/%h/%b/%0d",
          o.d0, o.d1, o.err, o.cnt, e.d0, e.d1, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back;
    res_t       e;
    res_t       o;
    logic [7:0] tr;
    logic       rn;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       tr = 8'h00;
        3:       tr = 8'($urandom);
        default: tr = 8'(1 << $urandom_range(0, 7));
      endcase
      rn = ($urandom_range(0, 79) != 0);
      drive(tr, $urandom, 3'($urandom), 3'($urandom), rn);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b: got %h/%h/%b/%0d want %h/%h/%b/%0d",
          o.d0, o.d1, o.err, o.cnt, e.d0, e.d1, e.err, e.cnt);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_err   = 1'b0;
    m_cnt   = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    reset_n = 1'b0;
    to_reg  = '0;
    wData   = '0;
    rAddr0  = '0;
    rAddr1  = '0;
    test_reset();
    test_write_read();
    test_multi_hot();
    test_saturation();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
